// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, reads the instruction
// memory combinationally and buffers {pc, instruction} pairs in a small FIFO
// that feeds decode over a valid/ready handshake. A redirect flushes the
// FIFO and reloads the PC; a misaligned redirect target halts fetching
// until reset and raises a sticky error flag.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     misaligned_err
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          misErr_q, misErr_d;
    logic [31:0]   instrBuf_q [DEPTH];
    logic [31:0]   pcBuf_q    [DEPTH];

    logic          headValid;
    logic          pop;
    logic          push;

    // Handshake decode and next-state selection; a redirect overrides
    // everything, so decode never sees a pop in the redirect cycle.
    always_comb begin
        headValid = (count_q != '0) && !redirect_valid;
        pop       = headValid && out_ready;
        push      = !misErr_q && !redirect_valid && ((count_q < FULL_COUNT) || pop);

        fetchPc_d = fetchPc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        misErr_d  = misErr_q;

        if (redirect_valid) begin
            fetchPc_d = {redirect_target[31:2], 2'b00};
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            misErr_d  = misErr_q || (redirect_target[1:0] != 2'b00);
        end else begin
            if (push) begin
                fetchPc_d = fetchPc_q + 32'd4;
                tail_d    = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // PC, FIFO pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc_q <= RESET_PC;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            misErr_q  <= 1'b0;
        end else begin
            fetchPc_q <= fetchPc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            misErr_q  <= misErr_d;
        end
    end

    // FIFO storage: the word returned for the current fetch PC lands at the tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instrBuf_q[i] <= '0;
                pcBuf_q[i]    <= '0;
            end
        end else if (push) begin
            instrBuf_q[tail_q] <= imem_rdata;
            pcBuf_q[tail_q]    <= fetchPc_q;
        end
    end

    assign imem_addr      = fetchPc_q;
    assign out_valid      = headValid;
    assign out_instr      = instrBuf_q[head_q];
    assign out_pc         = pcBuf_q[head_q];
    assign buf_count      = count_q;
    assign misaligned_err = misErr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Two instances share the clock: one at
// the default reset PC, one starting near the top of the address space to
// exercise PC wrap. Memory returns word == address for both.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset, reset2;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        outReady, outReady2;

    logic [31:0] imemAddr, imemAddr2;
    logic [31:0] outInstr, outInstr2;
    logic [31:0] outPc, outPc2;
    logic        outValid, outValid2;
    logic [2:0]  bufCount, bufCount2;
    logic        misErr, misErr2;
    logic        noRedirect;
    logic [31:0] zeroTarget;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imemAddr),
        .imem_rdata      (imemAddr),
        .redirect_valid  (redirectValid),
        .redirect_target (redirectTarget),
        .out_valid       (outValid),
        .out_ready       (outReady),
        .out_instr       (outInstr),
        .out_pc          (outPc),
        .buf_count       (bufCount),
        .misaligned_err  (misErr)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dutWrap (
        .clk             (clk),
        .reset           (reset2),
        .imem_addr       (imemAddr2),
        .imem_rdata      (imemAddr2),
        .redirect_valid  (noRedirect),
        .redirect_target (zeroTarget),
        .out_valid       (outValid2),
        .out_ready       (outReady2),
        .out_instr       (outInstr2),
        .out_pc          (outPc2),
        .buf_count       (bufCount2),
        .misaligned_err  (misErr2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic rv,
                                 input logic [31:0] tgt, input logic rst2, input logic rdy2);
        @(negedge clk);
        reset          = rst;
        outReady       = rdy;
        redirectValid  = rv;
        redirectTarget = tgt;
        reset2         = rst2;
        outReady2      = rdy2;
        #1;
    endtask

    // One comparison with pass/fail bookkeeping.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        logic [31:0] expPc;
        logic        rdy;

        reset = 1'b1; reset2 = 1'b1; outReady = 1'b0; outReady2 = 1'b0;
        redirectValid = 1'b0; redirectTarget = '0;
        noRedirect = 1'b0; zeroTarget = '0;

        // Reset state
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_pc", outPc, 0);
        checkOutput("rst_instr", outInstr, 0);
        checkOutput("rst_count", bufCount, 0);
        checkOutput("rst_addr", imemAddr, 0);
        checkOutput("rst_err", misErr, 0);
        checkOutput("rst_addr2", imemAddr2, 32'hFFFF_FFF8);

        // Streaming with out_ready=1
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("s_first_addr", imemAddr, 0);
        checkOutput("s_first_valid", outValid, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0, 0, 1, 0);
            checkOutput("s_valid", outValid, 1);
            checkOutput("s_pc", outPc, 32'(4 * k));
            checkOutput("s_instr", outInstr, 32'(4 * k));
            checkOutput("s_count", bufCount, 1);
        end

        // Fill with out_ready=0, then drain gap-free
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput("f_count", bufCount, (c < 4) ? c : 4);
            checkOutput("f_addr", imemAddr, (c < 4) ? 32'(4 * c) : 32'd16);
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0, 0, 1, 0);
            checkOutput("d_valid", outValid, 1);
            checkOutput("d_pc", outPc, 32'(4 * k));
        end

        // Redirect to 44 with three buffered entries
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 1, 32'd44, 1, 0);
        checkOutput("r_cycle_valid", outValid, 0);
        checkOutput("r_cycle_count", bufCount, 3);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("r_flush_count", bufCount, 0);
        checkOutput("r_flush_valid", outValid, 0);
        checkOutput("r_flush_addr", imemAddr, 32'd44);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("r_t_valid", outValid, 1);
        checkOutput("r_t_pc", outPc, 32'd44);
        checkOutput("r_t_instr", outInstr, 32'd44);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("r_t2_pc", outPc, 32'd48);

        // Misaligned redirect to 0x46
        applyStimulus(0, 1, 1, 32'h0000_0046, 1, 0);
        checkOutput("m_cycle_valid", outValid, 0);
        checkOutput("m_cycle_err", misErr, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 0, 1, 0);
            checkOutput("m_err", misErr, 1);
            checkOutput("m_addr", imemAddr, 32'h44);
            checkOutput("m_count", bufCount, 0);
            checkOutput("m_valid", outValid, 0);
        end
        applyStimulus(0, 1, 1, 32'h100, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("m_re_addr", imemAddr, 32'h100);
        checkOutput("m_re_err", misErr, 1);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("m_re_hold", imemAddr, 32'h100);
        checkOutput("m_re_count", bufCount, 0);

        // Full buffer with out_ready toggling
        applyStimulus(1, 0, 0, 0, 1, 0);
        for (int c = 0; c < 6; c++) applyStimulus(0, 0, 0, 0, 1, 0);
        expPc = 32'd0;
        for (int k = 0; k < 8; k++) begin
            rdy = (k % 2 == 0);
            applyStimulus(0, rdy, 0, 0, 1, 0);
            checkOutput("t_count", bufCount, 4);
            checkOutput("t_valid", outValid, 1);
            checkOutput("t_pc", outPc, expPc);
            if (rdy) expPc = expPc + 32'd4;
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t_end_pc", outPc, 32'd16);
        checkOutput("t_end_addr", imemAddr, 32'd32);

        // PC wrap on the second instance, then asynchronous reset mid-stream
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("w_first_addr", imemAddr2, 32'hFFFF_FFF8);
        checkOutput("w_first_valid", outValid2, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("w_pc0", outPc2, 32'hFFFF_FFF8);
        checkOutput("w_instr0", outInstr2, 32'hFFFF_FFF8);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("w_pc1", outPc2, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("w_pc2", outPc2, 32'h0000_0000);
        checkOutput("w_valid2", outValid2, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("w_pc3", outPc2, 32'h0000_0004);
        #2;
        reset2 = 1'b1;
        #1;
        checkOutput("a_valid", outValid2, 0);
        checkOutput("a_pc", outPc2, 0);
        checkOutput("a_instr", outInstr2, 0);
        checkOutput("a_count", bufCount2, 0);
        checkOutput("a_addr", imemAddr2, 32'hFFFF_FFF8);
        checkOutput("a_err", misErr2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
